// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared state type and packet constants for debug_uart_tx.
// Defining DEBUG_UART_TX_CHECKSUM_EN grows the packet by one XOR checksum byte.
package debug_uart_pkg;
   typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} uart_state_e;
   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
`ifdef DEBUG_UART_TX_CHECKSUM_EN
   localparam int PKT_BYTES = 9;
`else
   localparam int PKT_BYTES = 8;
`endif
   localparam int IDX_W = $clog2(PKT_BYTES);
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: sends one 8N1 byte LSB first; accepts the next byte in the
// last stop-bit cycle so consecutive bytes leave no idle gap on the line.
module uart_tx_byte
   import debug_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   uart_state_e r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic r_tx, w_tx_nxt;
   logic w_tick;
   assign w_tick = r_cnt == CNT_MAX;
   assign o_ready = (r_state == IDLE) || (r_state == STOP_BIT && w_tick);
   assign o_tx = r_tx;
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_bit <= '0;
         r_data <= '0;
         r_tx <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt <= w_cnt_nxt;
         r_bit <= w_bit_nxt;
         r_data <= w_data_nxt;
         r_tx <= w_tx_nxt;
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
      w_bit_nxt = r_bit;
      w_data_nxt = r_data;
      w_tx_nxt = r_tx;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            w_tx_nxt = ~i_valid;
            w_state_nxt = i_valid ? START_BIT : IDLE;
            w_data_nxt = i_valid ? i_data : r_data;
         end
         START_BIT: if (w_tick) begin
            w_state_nxt = DATA_BITS;
            w_bit_nxt = '0;
            w_tx_nxt = r_data[0];
         end
         DATA_BITS: if (w_tick) begin
            w_state_nxt = (r_bit == 3'd7) ? STOP_BIT : DATA_BITS;
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt = (r_bit == 3'd7) ? 1'b1 : r_data[r_bit + 3'd1];
         end
         STOP_BIT: if (w_tick) begin
            w_state_nxt = i_valid ? START_BIT : IDLE;
            w_tx_nxt = ~i_valid;
            w_data_nxt = i_valid ? i_data : r_data;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots the seven CPU debug ports and sends HEADER + ports
// as back-to-back 8N1 bytes; DEBUG_UART_TX_CHECKSUM_EN appends their XOR.
module debug_uart_tx
   import debug_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic [7:0] debug_port1,
   input  logic [7:0] debug_port2,
   input  logic [7:0] debug_port3,
   input  logic [7:0] debug_port4,
   input  logic [7:0] debug_port5,
   input  logic [7:0] debug_port6,
   input  logic [7:0] debug_port7,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       tx
);
   logic [7:0] r_buf [PKT_BYTES];
   logic [IDX_W-1:0] r_byte_idx;
   logic r_busy, r_done;
   logic w_ready, w_last, w_accept, w_advance, w_finish, w_valid;
   logic [7:0] w_data;
   assign w_last = r_byte_idx == IDX_W'(PKT_BYTES - 1);
   // the done cycle is already idle, but a start seen there is still dropped
   assign w_accept = start && !r_busy && !r_done;
   assign w_advance = r_busy && w_ready && !w_last;
   assign w_finish = r_busy && w_ready && w_last;
   assign w_valid = w_accept || w_advance;
   // HEADER goes straight to the shifter so the start bit leaves on the snapshot edge
   assign w_data = w_accept ? HEADER : r_buf[r_byte_idx + 1'b1];
   assign busy = r_busy;
   assign done = r_done;
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[0] <= HEADER;
         r_buf[1] <= debug_port1;
         r_buf[2] <= debug_port2;
         r_buf[3] <= debug_port3;
         r_buf[4] <= debug_port4;
         r_buf[5] <= debug_port5;
         r_buf[6] <= debug_port6;
         r_buf[7] <= debug_port7;
`ifdef DEBUG_UART_TX_CHECKSUM_EN
         r_buf[8] <= debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                     debug_port5 ^ debug_port6 ^ debug_port7;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_byte_idx <= '0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_busy <= 1'b1;
            r_byte_idx <= '0;
         end else if (w_advance) begin
            r_byte_idx <= r_byte_idx + 1'b1;
         end else if (w_finish) begin
            r_busy <= 1'b0;
         end
      end
   end
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk    (clk),
      .nreset (nreset),
      .i_valid(w_valid),
      .i_data (w_data),
      .o_ready(w_ready),
      .o_tx   (tx)
   );
endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: scoreboard bench; a line decoder collects bytes from tx
// and each scenario compares them against bytes queued at stimulus time.
module tb_debug_uart_tx;
   localparam int CPB = 4;
`ifdef DEBUG_UART_TX_CHECKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   localparam int PKT_CYC = NB * 10 * CPB;
   logic clk = 1'b0, nreset = 1'b0, start = 1'b0;
   logic [7:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0, p5 = '0, p6 = '0, p7 = '0;
   logic busy, done, tx;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] exp_q[$], rx_q[$];
   bit m_rx = 1'b0;
   int m_cnt = 0;
   logic [7:0] m_sh = '0;

   debug_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .nreset(nreset),
      .debug_port1(p1), .debug_port2(p2), .debug_port3(p3), .debug_port4(p4),
      .debug_port5(p5), .debug_port6(p6), .debug_port7(p7),
      .start(start), .busy(busy), .done(done), .tx(tx)
   );

   always #5 clk = ~clk;

   // line decoder: samples mid-bit, CPB=4 so bit k centre is 4*(k+1)+2 cycles after start edge
   always @(negedge clk) begin
      if (!nreset) m_rx = 1'b0;
      else if (!m_rx) begin
         if (tx === 1'b0) begin m_rx = 1'b1; m_cnt = 0; end
      end else begin
         m_cnt++;
         if (m_cnt >= 6 && m_cnt <= 34 && m_cnt % 4 == 2) m_sh[m_cnt/4-1] = tx;
         if (m_cnt == 38) begin m_rx = 1'b0; rx_q.push_back(m_sh); end
      end
   end

   task automatic set_ports(input logic [55:0] p);
      {p7, p6, p5, p4, p3, p2, p1} = p;
   endtask

   task automatic push_exp(input logic [55:0] p);
      logic [7:0] c = '0;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back(p[8*k +: 8]);
         c ^= p[8*k +: 8];
      end
`ifdef DEBUG_UART_TX_CHECKSUM_EN
      exp_q.push_back(c);
`endif
   endtask

   task automatic launch(input logic [55:0] p);
      set_ports(p);
      push_exp(p);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic watch(output int bc, output int dc, output bit to);
      bc = 0; dc = 0; to = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (busy === 1'b1) bc++;
         if (done === 1'b1) dc++;
         if (busy === 1'b0) begin
            to = 1'b0;
            repeat (3) begin @(negedge clk); if (done === 1'b1) dc++; end
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) begin
         start = 1'b1;
         @(negedge clk);
         n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      end
      start = 1'b0;
      nreset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL reset_no_frame: got %0d bytes want 0", rx_q.size()); end
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
      rx_q.delete();
   endtask

   task automatic test_basic;
      int bc, dc; bit to; logic [7:0] e, r;
      launch(56'h07060504030201);
      watch(bc, dc, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout: busy never fell within 2000 cycles"); end
      n_cmp++; if (bc != PKT_CYC) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, PKT_CYC); end
      n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front(); r = rx_q.pop_front();
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL basic_byte: got %h want %h", r, e); end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_snapshot;
      int bc, dc; bit to; logic [7:0] e, r;
      launch(56'h07060504030201);
      fork
         watch(bc, dc, to);
         begin repeat (2) @(negedge clk); set_ports('1); end
      join
      n_cmp++; if (to || bc != PKT_CYC) begin n_bad++; $display("FAIL snap_busy_cycles: got %0d want %0d", bc, PKT_CYC); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL snap_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front(); r = rx_q.pop_front();
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL snap_byte: got %h want %h", r, e); end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_busy_ignore;
      int bc, dc; bit to; logic [7:0] e, r;
      launch(56'h3C5A96E1_0F7788);
      fork
         watch(bc, dc, to);
         begin repeat (99) @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0; end
      join
      n_cmp++; if (to || bc != PKT_CYC) begin n_bad++; $display("FAIL ignore_busy_cycles: got %0d want %0d", bc, PKT_CYC); end
      n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL ignore_done_pulses: got %0d want 1", dc); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ignore_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front(); r = rx_q.pop_front();
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL ignore_byte: got %h want %h", r, e); end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_done_start;
      int bc, dc, n; bit to; logic [7:0] e, r;
      launch(56'hDEADBEEF123456);
      n = 0;
      while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL donestart_timeout: done never rose within 2000 cycles"); end
      start = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL donestart_ignored: busy got %b want 0", busy); end
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL donestart_next: busy got %b want 1", busy); end
      push_exp(56'hDEADBEEF123456);
      watch(bc, dc, to);
      n_cmp++; if (to || bc != PKT_CYC) begin n_bad++; $display("FAIL donestart_busy_cycles: got %0d want %0d", bc, PKT_CYC); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL donestart_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front(); r = rx_q.pop_front();
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL donestart_byte: got %h want %h", r, e); end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_midreset;
      int bc, dc; bit to; logic [7:0] e, r;
      launch(56'h07060504030201);
      repeat (149) @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midreset_tx: got %b want 1", tx); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
      nreset = 1'b1;
      @(negedge clk);
      exp_q.delete(); rx_q.delete();
      launch(56'h0F1E2D3C4B5A69);
      watch(bc, dc, to);
      n_cmp++; if (to || bc != PKT_CYC) begin n_bad++; $display("FAIL midreset_busy_cycles: got %0d want %0d", bc, PKT_CYC); end
      n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL midreset_done_pulses: got %0d want 1", dc); end
      n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midreset_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front(); r = rx_q.pop_front();
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL midreset_byte: got %h want %h", r, e); end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_patterns;
      int bc, dc; bit to; logic [7:0] e, r;
      logic [55:0] pats [3] = '{56'h77665544332211, 56'h00000000000080, 56'h07060504030201};
      for (int i = 0; i < 3; i++) begin
         launch(pats[i]);
         watch(bc, dc, to);
         n_cmp++; if (to || bc != PKT_CYC) begin n_bad++; $display("FAIL pat%0d_busy_cycles: got %0d want %0d", i, bc, PKT_CYC); end
         n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL pat%0d_len: got %0d want %0d", i, rx_q.size(), exp_q.size()); end
         while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            n_cmp++; if (r !== e) begin n_bad++; $display("FAIL pat%0d_byte: got %h want %h", i, r, e); end
         end
         exp_q.delete(); rx_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_snapshot();
      test_busy_ignore();
      test_done_start();
      test_midreset();
      test_patterns();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
